// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter (port 0 = core, port 1 = DMA/debug) in front of a
// single-ported data memory. One access every two cycles: grant, access, respond.
// Port 0 has priority; port 1 is forced through after STARVE_LIMIT lost arbitrations.
// Optional misalignment check: define DMEM_ARB_MISALIGN_CHK_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port 0 (core)
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [2:0]            p0_funct3,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  // port 1 (DMA/debug)
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [2:0]            p1_funct3,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  // data memory command
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                  state, state_next;
  logic [3:0]              starve_cnt;
  logic                    p1_wins;
  logic                    accept;
  logic                    misaligned;

  // Command latched at accept time; drives the memory during ACCESS.
  logic                    lat_we;
  logic [2:0]              lat_funct3;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic                    lat_port;

  logic [DATA_WIDTH-1:0]   rsp_data;

  // Next-state decode and combinational grant (accepts in IDLE and RESP).
  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    p1_wins    = 1'b0;
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    case (state)
      IDLE, RESP: begin
        p1_wins    = p1_req && (!p0_req || (starve_cnt == STARVE_MAX));
        p0_gnt     = p0_req && !p1_wins;
        p1_gnt     = p1_wins;
        state_next = (p0_req || p1_req) ? ACCESS : IDLE;
      end
      ACCESS:  state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  assign accept = p0_gnt || p1_gnt;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Starvation counter: counts port 1 losses, cleared when port 1 wins or stops asking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (p1_gnt) begin
      starve_cnt <= '0;
    end else if (p0_gnt && p1_req) begin
      if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
    end else if ((state != ACCESS) && !p1_req) begin
      starve_cnt <= '0;
    end
  end

  // Capture the winner's command on accept; held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_port   <= 1'b0;
    end else if (accept) begin
      lat_we     <= p1_gnt ? p1_we     : p0_we;
      lat_funct3 <= p1_gnt ? p1_funct3 : p0_funct3;
      lat_addr   <= p1_gnt ? p1_addr   : p0_addr;
      lat_wdata  <= p1_gnt ? p1_wdata  : p0_wdata;
      lat_port   <= p1_gnt;
    end
  end

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  assign misaligned = (((lat_funct3 == 3'b001) || (lat_funct3 == 3'b101)) && lat_addr[0]) ||
                      ((lat_funct3 == 3'b010) && (lat_addr[1:0] != 2'b00));

  logic rsp_err;

  // Response register: load data (zero for stores/misaligned) and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_data <= (lat_we || misaligned) ? '0 : mem_rd_data;
      rsp_err  <= misaligned;
    end
  end

  assign p0_err = rsp_err;
  assign p1_err = rsp_err;
`else
  assign misaligned = 1'b0;

  // Response register: load data, zero for stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rsp_data <= '0;
    else if (state == ACCESS)  rsp_data <= lat_we ? '0 : mem_rd_data;
  end

  assign p0_err = 1'b0;
  assign p1_err = 1'b0;
`endif

  // Memory command: write strobe only in ACCESS, other fields hold the latched command.
  assign mem_wr_en   = (state == ACCESS) && lat_we && !misaligned;
  assign mem_funct3  = lat_funct3;
  assign mem_addr    = lat_addr;
  assign mem_wr_data = lat_wdata;

  // Completion pulse goes only to the port that owns the access.
  assign p0_rvalid = (state == RESP) && !lat_port;
  assign p1_rvalid = (state == RESP) &&  lat_port;
  assign p0_rdata  = rsp_data;
  assign p1_rdata  = rsp_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven single transactions plus sequences for
// starvation rotation, reset during ACCESS and the reset state.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [2:0]  p0_funct3;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [2:0]  p1_funct3;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  localparam logic MIS_ON = 1'b1;
`else
  localparam logic MIS_ON = 1'b0;
`endif

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p0_req, p0_we;
    logic [2:0]  p0_f3;
    logic [31:0] p0_addr, p0_wdata;
    logic        p1_req, p1_we;
    logic [2:0]  p1_f3;
    logic [31:0] p1_addr, p1_wdata;
    logic [31:0] rd;
    logic        exp_port, exp_we;
    logic [2:0]  exp_f3;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_funct3 = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_funct3 = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  // One transaction: grant at T, memory command at T+1, response at T+2.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    p0_req = v.p0_req; p0_we = v.p0_we; p0_funct3 = v.p0_f3; p0_addr = v.p0_addr; p0_wdata = v.p0_wdata;
    p1_req = v.p1_req; p1_we = v.p1_we; p1_funct3 = v.p1_f3; p1_addr = v.p1_addr; p1_wdata = v.p1_wdata;
    mem_rd_data = v.rd;
    #1;
    check($sformatf("v%0d p0_gnt", idx), p0_gnt, !v.exp_port);
    check($sformatf("v%0d p1_gnt", idx), p1_gnt, v.exp_port);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check($sformatf("v%0d mem_wr_en", idx),   mem_wr_en,   v.exp_we);
    check($sformatf("v%0d mem_funct3", idx),  mem_funct3,  v.exp_f3);
    check($sformatf("v%0d mem_addr", idx),    mem_addr,    v.exp_addr);
    check($sformatf("v%0d mem_wr_data", idx), mem_wr_data, v.exp_wdata);
    @(negedge clk);
    check($sformatf("v%0d p0_rvalid", idx), p0_rvalid, !v.exp_port);
    check($sformatf("v%0d p1_rvalid", idx), p1_rvalid, v.exp_port);
    check($sformatf("v%0d rdata", idx), v.exp_port ? p1_rdata : p0_rdata, v.exp_rdata);
    check($sformatf("v%0d err", idx),   v.exp_port ? p1_err   : p0_err,   v.exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // fields: p0{req,we,f3,addr,wdata} p1{req,we,f3,addr,wdata} rd exp{port,we,f3,addr,wdata,rdata,err}
    vecs[0] = '{1'b1, 1'b0, 3'b010, 32'h8, 32'h0,
                1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h12345678,
                1'b0, 1'b0, 3'b010, 32'h8, 32'h0, 32'h12345678, 1'b0};            // p0 lw 0x8
    vecs[1] = '{1'b0, 1'b0, 3'b000, 32'h0, 32'h0,
                1'b1, 1'b1, 3'b000, 32'h3, 32'hAB, 32'hDEADBEEF,
                1'b1, 1'b1, 3'b000, 32'h3, 32'hAB, 32'h0, 1'b0};                   // p1 sb 0x3
    vecs[2] = '{1'b1, 1'b1, 3'b010, 32'h6, 32'h55,
                1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h11111111,
                1'b0, !MIS_ON, 3'b010, 32'h6, 32'h55, 32'h0, MIS_ON};              // p0 sw 0x6
    vecs[3] = '{1'b0, 1'b0, 3'b000, 32'h0, 32'h0,
                1'b1, 1'b0, 3'b101, 32'h11, 32'h0, 32'hCAFEF00D,
                1'b1, 1'b0, 3'b101, 32'h11, 32'h0,
                MIS_ON ? 32'h0 : 32'hCAFEF00D, MIS_ON};                            // p1 lhu 0x11
    vecs[4] = '{1'b1, 1'b0, 3'b001, 32'h2, 32'h77,
                1'b1, 1'b0, 3'b010, 32'h4, 32'h99, 32'h0000BEEF,
                1'b0, 1'b0, 3'b001, 32'h2, 32'h77, 32'h0000BEEF, 1'b0};            // both, p0 wins
    vecs[5] = '{1'b1, 1'b0, 3'b100, 32'h7, 32'h0,
                1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h000000FF,
                1'b0, 1'b0, 3'b100, 32'h7, 32'h0, 32'h000000FF, 1'b0};             // p0 lbu 0x7
    vecs[6] = '{1'b1, 1'b1, 3'b001, 32'hA, 32'h1234,
                1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h87654321,
                1'b0, 1'b1, 3'b001, 32'hA, 32'h1234, 32'h0, 1'b0};                 // p0 sh 0xA

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    mem_rd_data = 32'hFFFF_FFFF;
    #3;
    check("rst p0_gnt", p0_gnt, 0);
    check("rst p1_gnt", p1_gnt, 0);
    check("rst rvalid", {p0_rvalid, p1_rvalid}, 0);
    check("rst err", {p0_err, p1_err}, 0);
    check("rst mem_wr_en", mem_wr_en, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst rdata", p0_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Both ports request continuously: four p0 grants then one forced p1 grant.
    begin
      int gcount   = 0;
      int last_cyc = 0;
      logic last_port = 1'b0;
      @(negedge clk);
      p0_req = 1; p0_funct3 = 3'b010; p0_addr = 32'h100;
      p1_req = 1; p1_funct3 = 3'b010; p1_addr = 32'h200;
      mem_rd_data = 32'h0;
      for (int cyc = 0; cyc < 40 && gcount < 12; cyc++) begin
        #1;
        check($sformatf("starve onehot c%0d", cyc), p0_gnt & p1_gnt, 0);
        if (p0_gnt || p1_gnt) begin
          check($sformatf("starve order g%0d", gcount), p1_gnt, (gcount % 5) == 4);
          if (gcount > 0) begin
            check($sformatf("starve spacing g%0d", gcount), cyc - last_cyc, 2);
            check($sformatf("starve rvalid g%0d", gcount),
                  last_port ? p1_rvalid : p0_rvalid, 1);
          end
          last_cyc  = cyc;
          last_port = p1_gnt;
          gcount++;
        end
        @(negedge clk);
      end
      check("starve grant count", gcount, 12);
      idle_inputs();
      repeat (3) @(negedge clk);
    end

    // Reset asserted in ACCESS of a p0 store aborts it.
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_funct3 = 3'b010; p0_addr = 32'h4; p0_wdata = 32'hA5A5;
    #1;
    check("abort p0_gnt", p0_gnt, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("abort access wr_en", mem_wr_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort wr_en drop", mem_wr_en, 0);
    check("abort mem_addr clr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort no rvalid %0d", k), {p0_rvalid, p1_rvalid}, 0);
    end
    // Fresh port-1 load after reset behaves as from IDLE with cleared response register.
    check("abort rdata clr", p0_rdata, 0);
    p1_req = 1; p1_funct3 = 3'b010; p1_addr = 32'h20;
    mem_rd_data = 32'h5A;
    #1;
    check("post-rst p1_gnt", p1_gnt, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("post-rst wr_en", mem_wr_en, 0);
    check("post-rst mem_addr", mem_addr, 32'h20);
    @(negedge clk);
    check("post-rst p1_rvalid", p1_rvalid, 1);
    check("post-rst p0_rvalid", p0_rvalid, 0);
    check("post-rst p1_rdata", p1_rdata, 32'h5A);
    @(negedge clk);
    check("post-rst pulse end", p1_rvalid, 0);
    check("post-rst rdata hold", p1_rdata, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
